// File: rtl/ext_port_agent_if.sv
// Host-side bundle for ext_port_agent: ingress write channel plus capture read channel.
// The host uses the master modport and the agent uses the slave modport.
interface ext_port_agent_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_port;
  logic [7:0]  in_data;
  logic        cap_valid;
  logic        cap_ready;
  logic [1:0]  cap_port;
  logic [7:0]  cap_data;
  logic [15:0] cap_time;
  logic        cap_overflow;
  logic        ovf_clr;

  modport master (
    output in_valid, in_port, in_data, cap_ready, ovf_clr,
    input  in_ready, cap_valid, cap_port, cap_data, cap_time, cap_overflow
  );

  modport slave (
    input  in_valid, in_port, in_data, cap_ready, ovf_clr,
    output in_ready, cap_valid, cap_port, cap_data, cap_time, cap_overflow
  );
endinterface

// File: rtl/ext_port_agent.sv
// ext_port_agent: drives the four processor input ports from a host write
// channel and records changes on the four processor output ports into a
// first-word-fall-through capture FIFO.
// Optional feature: define EXT_PORT_TIMESTAMP_EN to stamp each record with a
// 16-bit free-running cycle count; otherwise cap_time is tied to zero.
//
// Ingress FSM
//   state    | meaning
//   ST_BOOT  | first cycle after reset, in_ready still low
//   ST_READY | in_ready high, waiting for a transfer
//   ST_HOLD  | in_ready low, holdCnt counting down to terminal count 0
module ext_port_agent #(
  parameter int CAP_DEPTH = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             Reset,
  ext_port_agent_if.slave  bus,
  output logic [7:0]       InpExtWorld1,
  output logic [7:0]       InpExtWorld2,
  output logic [7:0]       InpExtWorld3,
  output logic [7:0]       InpExtWorld4,
  input  logic [7:0]       OutExtWorld1,
  input  logic [7:0]       OutExtWorld2,
  input  logic [7:0]       OutExtWorld3,
  input  logic [7:0]       OutExtWorld4
);

  localparam int              AW         = $clog2(CAP_DEPTH);
  localparam int              CW         = AW + 1;
  localparam bit              HOLD_EN    = (HOLD_CYC > 0);
  localparam logic [3:0]      HOLD_LOAD  = HOLD_EN ? 4'(HOLD_CYC - 1) : 4'd0;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(CAP_DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_READY, ST_HOLD} ingState_t;

  ingState_t       ingState;
  logic [3:0]      holdCnt;
  logic            inReady;
  logic            xfer;
  logic [3:0][7:0] inpPort;

  logic [3:0][7:0] outNow;
  logic [3:0][7:0] outPrev;
  logic [3:0]      changed;
  logic [3:0]      pending;
  logic [3:0]      pushMask;
  logic [1:0]      pushPort;
  logic            pushReq;

  logic [CW-1:0]   count;
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic [1:0]      memPort [CAP_DEPTH];
  logic [7:0]      memData [CAP_DEPTH];
  logic            full;
  logic            capValid;
  logic            pop;
  logic            doWrite;
  logic            drop;
  logic            ovfFlag;

  assign xfer         = bus.in_valid && inReady;
  assign bus.in_ready = inReady;

  assign InpExtWorld1 = inpPort[0];
  assign InpExtWorld2 = inpPort[1];
  assign InpExtWorld3 = inpPort[2];
  assign InpExtWorld4 = inpPort[3];

  // Ingress handshake: in_ready rises one edge after reset and drops for HOLD_CYC cycles per transfer.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ingState <= ST_BOOT;
      holdCnt  <= 4'd0;
      inReady  <= 1'b0;
    end else begin
      case (ingState)
        ST_BOOT: begin
          ingState <= ST_READY;
          inReady  <= 1'b1;
        end
        ST_READY: begin
          if (xfer && HOLD_EN) begin
            ingState <= ST_HOLD;
            inReady  <= 1'b0;
            holdCnt  <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (holdCnt == 4'd0) begin
            ingState <= ST_READY;
            inReady  <= 1'b1;
          end else begin
            holdCnt <= holdCnt - 4'd1;
          end
        end
        default: begin
          ingState <= ST_BOOT;
          inReady  <= 1'b0;
        end
      endcase
    end
  end

  // Selected input port takes the ingress byte on a transfer; the rest hold.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      inpPort <= '0;
    end else if (xfer) begin
      inpPort[bus.in_port] <= bus.in_data;
    end
  end

  assign outNow = {OutExtWorld4, OutExtWorld3, OutExtWorld2, OutExtWorld1};

  // Compare each output port against its copy from the previous cycle.
  always_comb begin
    changed = '0;
    for (int i = 0; i < 4; i++) begin
      changed[i] = (outNow[i] != outPrev[i]);
    end
  end

  // Lowest-index pending port wins the single push slot; descending scan lets it overwrite.
  always_comb begin
    pushMask = '0;
    pushPort = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        pushMask = 4'b0001 << i;
        pushPort = 2'(i);
      end
    end
  end

  assign pushReq  = |pending;
  assign full     = (count == FULL_COUNT);
  assign capValid = (count != '0);
  assign pop      = capValid && bus.cap_ready;
  assign doWrite  = pushReq && (!full || pop);
  assign drop     = pushReq && full && !pop;

  // Change detector: new changes merge into pending; the pushed (or dropped) bit clears.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      outPrev <= '0;
      pending <= '0;
    end else begin
      outPrev <= outNow;
      pending <= (pending & ~pushMask) | changed;
    end
  end

  // Capture FIFO pointers, occupancy and storage; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < CAP_DEPTH; i++) begin
        memPort[i] <= '0;
        memData[i] <= '0;
      end
    end else begin
      if (doWrite) begin
        memPort[wrPtr] <= pushPort;
        memData[wrPtr] <= outNow[pushPort];
        wrPtr          <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doWrite, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ovfFlag <= 1'b0;
    end else if (drop) begin
      ovfFlag <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovfFlag <= 1'b0;
    end
  end

  assign bus.cap_valid    = capValid;
  assign bus.cap_port     = memPort[rdPtr];
  assign bus.cap_data     = memData[rdPtr];
  assign bus.cap_overflow = ovfFlag;

`ifdef EXT_PORT_TIMESTAMP_EN
  logic [15:0] cycCnt;
  logic [15:0] memTime [CAP_DEPTH];

  // Free-running cycle stamp, sampled into the record in its push cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cycCnt <= 16'h0000;
      for (int i = 0; i < CAP_DEPTH; i++) begin
        memTime[i] <= 16'h0000;
      end
    end else begin
      cycCnt <= cycCnt + 16'd1;
      if (doWrite) begin
        memTime[wrPtr] <= cycCnt;
      end
    end
  end

  assign bus.cap_time = memTime[rdPtr];
`else
  assign bus.cap_time = 16'h0000;
`endif

endmodule
